axi4_lite_master: RTL and testbench

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

---
 rtl/axi4_lite_master.sv | 163 ++++++++++++++++
 tb/tb_axi4_lite_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns one user command at a time into an AXI4-Lite read or
// write burst-free transaction and returns the slave response to the user.
module axi4_lite_master #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] M_AWADDR,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    output logic [31:0]           M_WDATA,
    output logic [3:0]            M_WSTRB,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    output logic [ADDR_WIDTH-1:0] M_ARADDR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [31:0]           M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t                state_q;
    logic                  cmd_ready_q;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_rdata_q;
    logic [1:0]            rsp_resp_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  awvalid_d;
    logic                  wvalid_d;

    // AW and W channels retire independently; each VALID falls only on its own handshake.
    always_comb begin
        awvalid_d = awvalid_q & ~M_AWREADY;
        wvalid_d  = wvalid_q & ~M_WREADY;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_write) begin
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            wstrb_q   <= cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            araddr_q  <= cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    awvalid_q <= awvalid_d;
                    wvalid_q  <= wvalid_d;
                    if (!awvalid_d && !wvalid_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_BVALID) begin
                        bready_q    <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= M_BRESP;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (M_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_RVALID) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= M_RDATA;
                        rsp_resp_q  <= M_RRESP;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign M_AWADDR  = awaddr_q;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_WVALID  = wvalid_q;
    assign M_BREADY  = bready_q;
    assign M_ARADDR  = araddr_q;
    assign M_ARVALID = arvalid_q;
    assign M_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: a reactive slave with configurable stalls plus a
// transaction-level model of the expected response, latency and handshake counts.
module tb_axi4_lite_master;

    localparam int AW = 32;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] M_AWADDR, M_ARADDR;
    logic          M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
    logic [31:0]   M_WDATA, M_RDATA;
    logic [3:0]    M_WSTRB;
    logic [1:0]    M_BRESP, M_RRESP;
    logic          M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    int n_checks = 0;
    int n_fail   = 0;

    // slave configuration and observed handshakes
    int          cfg_aw_dly, cfg_w_dly, cfg_ar_dly, cfg_b_dly, cfg_r_dly;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    bit          spur = 1'b0;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_wstrb;

    always #5 ACLK = ~ACLK;

    axi4_lite_master #(.ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave: all inputs change on the falling edge; handshakes of the preceding
    // rising edge are reconstructed from the values recorded one falling edge earlier.
    initial begin : slave
        bit p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr, spur_prev;
        logic [AW-1:0] p_awaddr, p_araddr;
        logic [31:0]   p_wdata;
        logic [3:0]    p_wstrb;
        bit aw_got, w_got, ar_got;
        int aw_wait, w_wait, ar_wait, b_wait, r_wait;
        M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0; M_BVALID = 0; M_RVALID = 0;
        M_BRESP = 0; M_RRESP = 0; M_RDATA = 0;
        {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr, spur_prev} = '0;
        p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_wstrb = 0;
        {aw_got, w_got, ar_got} = '0;
        {aw_wait, w_wait, ar_wait, b_wait, r_wait} = '0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0; M_BVALID = 0; M_RVALID = 0;
                {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr} = '0;
                {aw_got, w_got, ar_got} = '0;
                {aw_wait, w_wait, ar_wait, b_wait, r_wait} = '0;
            end else begin
                if (p_awv && !p_awr)
                    check_eq("aw_hold", 64'({M_AWVALID, M_AWADDR}), 64'({1'b1, p_awaddr}));
                if (p_wv && !p_wr)
                    check_eq("w_hold", 64'({M_WVALID, M_WSTRB, M_WDATA}), 64'({1'b1, p_wstrb, p_wdata}));
                if (p_arv && !p_arr)
                    check_eq("ar_hold", 64'({M_ARVALID, M_ARADDR}), 64'({1'b1, p_araddr}));
                if (p_awv && p_awr) begin aw_got = 1; cap_awaddr = p_awaddr; n_aw++; aw_wait = 0; end
                if (p_wv && p_wr) begin w_got = 1; cap_wdata = p_wdata; cap_wstrb = p_wstrb; n_w++; w_wait = 0; end
                if (p_arv && p_arr) begin ar_got = 1; cap_araddr = p_araddr; n_ar++; ar_wait = 0; end
                if (p_bv && p_br) begin aw_got = 0; w_got = 0; n_b++; M_BVALID = 0; b_wait = 0; end
                if (p_rv && p_rr) begin ar_got = 0; n_r++; M_RVALID = 0; r_wait = 0; end
                if (spur_prev && !spur) begin M_BVALID = 0; M_RVALID = 0; end

                M_AWREADY = 0;
                if (M_AWVALID) begin
                    if (aw_wait >= cfg_aw_dly) M_AWREADY = 1; else aw_wait++;
                end
                M_WREADY = 0;
                if (M_WVALID) begin
                    if (w_wait >= cfg_w_dly) M_WREADY = 1; else w_wait++;
                end
                M_ARREADY = 0;
                if (M_ARVALID) begin
                    if (ar_wait >= cfg_ar_dly) M_ARREADY = 1; else ar_wait++;
                end
                if (aw_got && w_got && !M_BVALID) begin
                    if (b_wait >= cfg_b_dly) begin M_BVALID = 1; M_BRESP = cfg_bresp; end
                    else b_wait++;
                end
                if (ar_got && !M_RVALID) begin
                    if (r_wait >= cfg_r_dly) begin M_RVALID = 1; M_RDATA = cfg_rdata; M_RRESP = cfg_rresp; end
                    else r_wait++;
                end
                if (spur) begin
                    M_BVALID = 1; M_RVALID = 1; M_BRESP = 2'b11; M_RRESP = 2'b11; M_RDATA = $urandom;
                end
                spur_prev = spur;
                p_awv = M_AWVALID; p_awr = M_AWREADY; p_awaddr = M_AWADDR;
                p_wv = M_WVALID; p_wr = M_WREADY; p_wdata = M_WDATA; p_wstrb = M_WSTRB;
                p_arv = M_ARVALID; p_arr = M_ARREADY; p_araddr = M_ARADDR;
                p_bv = M_BVALID; p_br = M_BREADY; p_rv = M_RVALID; p_rr = M_RREADY;
            end
        end
    end

    // One complete user transaction; expectations come from the slave setup alone.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_d, input int w_d, input int ar_d,
                           input int b_d, input int r_d, input logic [1:0] resp, input int rr_d);
        int lat, arv, t, exp_lat, n_aw0, n_w0, n_b0, n_ar0, n_r0;
        logic [31:0] exp_rdata;
        cfg_aw_dly = aw_d; cfg_w_dly = w_d; cfg_ar_dly = ar_d; cfg_b_dly = b_d; cfg_r_dly = r_d;
        cfg_bresp = resp; cfg_rresp = resp; cfg_rdata = data;
        exp_rdata = wr ? 32'h0 : data;
        exp_lat = wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;
        n_aw0 = n_aw; n_w0 = n_w; n_b0 = n_b; n_ar0 = n_ar; n_r0 = n_r;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge ACLK); t++; end
        check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wr ? data : $urandom; cmd_wstrb = strb;
        @(negedge ACLK);
        cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        check_eq("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        lat = 1; arv = 0;
        while (!rsp_valid && lat < 300) begin
            if (M_ARVALID) arv++;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            @(negedge ACLK);
            lat++;
        end
        cmd_valid = 0;
        check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        check_eq("rsp_resp", 64'(rsp_resp), 64'(resp));
        if (!wr) check_eq("arvalid_cycles", 64'(arv), 64'(ar_d + 1));
        for (int i = 0; i < rr_d; i++) begin
            @(negedge ACLK);
            check_eq("rsp_hold", 64'({rsp_valid, rsp_resp, rsp_rdata, cmd_ready}),
                     64'({1'b1, resp, exp_rdata, 1'b0}));
        end
        rsp_ready = 1;
        @(negedge ACLK);
        rsp_ready = 0;
        check_eq("rsp_done", 64'({rsp_valid, cmd_ready}), 64'({1'b0, 1'b1}));
        if (wr) begin
            check_eq("awaddr", 64'(cap_awaddr), 64'(addr));
            check_eq("wdata", 64'({cap_wstrb, cap_wdata}), 64'({strb, data}));
            check_eq("wr_hs_counts", 64'({8'(n_aw - n_aw0), 8'(n_w - n_w0), 8'(n_b - n_b0), 8'(n_ar - n_ar0)}),
                     64'({8'd1, 8'd1, 8'd1, 8'd0}));
        end else begin
            check_eq("araddr", 64'(cap_araddr), 64'(addr));
            check_eq("rd_hs_counts", 64'({8'(n_ar - n_ar0), 8'(n_r - n_r0), 8'(n_aw - n_aw0), 8'(n_w - n_w0)}),
                     64'({8'd1, 8'd1, 8'd0, 8'd0}));
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int t;
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_ar_dly = 0; cfg_b_dly = 0; cfg_r_dly = 0;
        cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        ARESET = 0;
        #2 ARESET = 1;
        #1;
        check_eq("reset_outputs", 64'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}), 64'd0);
        check_eq("reset_rsp", 64'({rsp_rdata, rsp_resp}), 64'd0);
        repeat (3) @(negedge ACLK);
        ARESET = 0;
        @(negedge ACLK);
        check_eq("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // basic zero-wait write and delayed-ARREADY read
        run_txn(1, 32'h60, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0);
        run_txn(0, 32'(24 << 2), 32'hDEADBEEF, 4'h0, 0, 0, 4, 0, 0, 2'b00, 0);
        // W before AW, then AW before W
        run_txn(1, 32'h1004, 32'h12345678, 4'h5, 2, 0, 0, 0, 0, 2'b00, 0);
        run_txn(1, 32'h2008, 32'h9ABCDEF0, 4'hA, 0, 2, 0, 0, 0, 2'b00, 0);
        // error responses passed through, user back-pressure
        run_txn(0, 32'h300C, 32'hCAFEF00D, 4'h0, 0, 0, 0, 0, 1, 2'b10, 3);
        run_txn(1, 32'h4010, 32'h0BADC0DE, 4'h3, 1, 1, 0, 2, 0, 2'b11, 2);

        // stray slave responses while idle must be ignored
        spur = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check_eq("spurious_idle", 64'({rsp_valid, cmd_ready, M_BREADY, M_RREADY}), 64'({1'b0, 1'b1, 1'b0, 1'b0}));
        end
        spur = 0;
        repeat (2) @(negedge ACLK);

        // reset while waiting for the write response
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 8; cfg_bresp = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h5014; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
        @(negedge ACLK);
        cmd_valid = 0;
        t = 0;
        while (!M_BREADY && t < 20) begin @(negedge ACLK); t++; end
        check_eq("in_wr_resp", 64'(M_BREADY), 64'd1);
        #2 ARESET = 1;
        #1;
        check_eq("async_reset_ctl", 64'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}), 64'd0);
        check_eq("async_reset_data", 64'({M_AWADDR, M_WDATA}), 64'd0);
        @(negedge ACLK);
        #2 ARESET = 0;
        @(negedge ACLK);
        check_eq("cmd_ready_post_reset", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            check_eq("no_rsp_after_reset", 64'(rsp_valid), 64'd0);
        end
        run_txn(1, 32'h6018, 32'h13579BDF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
